vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator, the successor to hvsync_generator.
//  - Produces hsync/vsync, the display-area flag and pixel coordinates for the pixel
//    renderer and game-object logic.
//  - Adds generic timing and sync polarity, a pixel-enable input (board clock can run
//    faster than the pixel rate), and line-start/frame-start strobes.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    hsync asserted level (0 = active-low)
//  VS_POL    0    vsync asserted level (0 = active-low)
//  CX_W      10   counter_x width; must hold H_TOTAL-1
//  CY_W      10   counter_y width; must hold V_TOTAL-1
// PORTS
//  clk          in   1     system/pixel clock, rising edge
//  reset_n      in   1     asynchronous reset, active-low
//  pix_en       in   1     pixel-advance enable; tie to 1 when clk is the pixel clock
//  h_sync       out  1     horizontal sync, polarity HS_POL
//  v_sync       out  1     vertical sync, polarity VS_POL
//  in_display   out  1     1 when counter_x<H_ACTIVE and counter_y<V_ACTIVE
//  counter_x    out  CX_W  current pixel column
//  counter_y    out  CY_W  current line
//  line_start   out  1     1-clk pulse, cycle in which counter_x becomes 0
//  frame_start  out  1     1-clk pulse, cycle in which (x,y) becomes (0,0)
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - Elaboration check: if 2**CX_W < H_TOTAL or 2**CY_W < V_TOTAL -> $error.
//  - Reset (async on reset_n low, held while low):
//    - counter_x=H_TOTAL-1, counter_y=V_TOTAL-1
//    - h_sync=~HS_POL, v_sync=~VS_POL
//    - in_display=0, line_start=0, frame_start=0
//  - Clock edge with pix_en=1:
//    - counter_x increments; at H_TOTAL-1 it wraps to 0.
//    - counter_y increments on that x wrap; at V_TOTAL-1 it wraps to 0.
//  - Clock edge with pix_en=0: counters and syncs hold; strobes go to 0.
//  - All outputs are registers. Syncs and in_display are decoded from the next count,
//    so they are aligned with counter_x/counter_y in the same cycle (zero skew, 1-clk latency from pix_en).
//  - h_sync = HS_POL while H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
//  - v_sync = VS_POL while V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
//  - line_start: high for exactly 1 clk, even when pix_en is held low after the advance.
//  - frame_start: implies line_start in the same cycle.
//  - After reset release, the first pix_en edge moves to (0,0) and fires frame_start.
//  - Reset mid-frame: immediate return to reset values; no partial-line state survives.
// CONFIGURATION
//  VGA_FRAME_CNT_EN defined:
//    - Adds output frame_cnt [7:0].
//    - Reset value is 0; increments on each frame_start; wraps 255 -> 0.
//  VGA_FRAME_CNT_EN undefined:
//    - Port and register are absent; all other behaviour is identical.
// TESTING
//  1 Reset: reset_n=0 at defaults -> x=799, y=524, h_sync=1, v_sync=1, in_display=0.
//    Release with pix_en=1 -> next edge gives (0,0), frame_start=1 for 1 clk, in_display=1.
//  2 Line, pix_en=1 -> in_display falls at x=640; h_sync=0 for x=656..751 (96 clk);
//    line_start at 799->0, y+1; line period 800 clk.
//  3 Frame -> v_sync=0 for y=490..491 (1600 clk); frame_start period 420000 clk;
//    in_display=0 for y>=480.
//  4 pix_en 1-of-2 clocks -> counters step every 2nd clk; frame_start period 840000 clk;
//    strobe width stays 1 clk.
//  5 Async reset at (300,200) -> outputs take reset values without a clock edge.
//    Then run HS_POL=1, VS_POL=1 with 8/2/2/2 x 4/1/1/1 -> x 0..13, y 0..6;
//    h_sync=1 at x=10..11, v_sync=1 at y=5.
//  6 VGA_FRAME_CNT_EN with the small config -> frame_cnt 0->1 at the 1st post-reset frame_start;
//    after 256 frames it wraps 255->0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: syncs, display flag, coordinates and line/frame strobes.
// Optional VGA_FRAME_CNT_EN adds an 8-bit frame counter output; 1-clk latency from pix_en.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CX_W     = 10,
    parameter int   CY_W     = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pix_en,
    output logic            h_sync,
    output logic            v_sync,
    output logic            in_display,
    output logic [CX_W-1:0] counter_x,
    output logic [CY_W-1:0] counter_y,
    output logic            line_start,
`ifdef VGA_FRAME_CNT_EN
    output logic [7:0]      frame_cnt,
`endif
    output logic            frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One extra bit so a sync window ending exactly at 2**CX_W still compares correctly.
    localparam logic [CX_W:0] X_LAST   = (CX_W+1)'(H_TOTAL - 1);
    localparam logic [CX_W:0] X_ACT    = (CX_W+1)'(H_ACTIVE);
    localparam logic [CX_W:0] HS_START = (CX_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CX_W:0] HS_END   = (CX_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CY_W:0] Y_LAST   = (CY_W+1)'(V_TOTAL - 1);
    localparam logic [CY_W:0] Y_ACT    = (CY_W+1)'(V_ACTIVE);
    localparam logic [CY_W:0] VS_START = (CY_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CY_W:0] VS_END   = (CY_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if ((2**CX_W) < H_TOTAL || (2**CY_W) < V_TOTAL) begin : g_width_check
            $error("vga_timing_gen: CX_W/CY_W too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    logic            x_wrap;
    logic            y_wrap;
    logic [CX_W-1:0] x_nxt;
    logic [CY_W-1:0] y_nxt;
    logic [CX_W:0]   x_nxt_ext;
    logic [CY_W:0]   y_nxt_ext;
    logic            hs_act;
    logic            vs_act;
    logic            de_nxt;

    always_comb begin
        x_wrap    = ({1'b0, counter_x} == X_LAST);
        y_wrap    = ({1'b0, counter_y} == Y_LAST);
        x_nxt     = x_wrap ? '0 : counter_x + 1'b1;
        y_nxt     = counter_y;
        if (x_wrap) begin
            y_nxt = y_wrap ? '0 : counter_y + 1'b1;
        end
        x_nxt_ext = {1'b0, x_nxt};
        y_nxt_ext = {1'b0, y_nxt};
        hs_act    = (x_nxt_ext >= HS_START) && (x_nxt_ext < HS_END);
        vs_act    = (y_nxt_ext >= VS_START) && (y_nxt_ext < VS_END);
        de_nxt    = (x_nxt_ext < X_ACT) && (y_nxt_ext < Y_ACT);
    end

    // Everything is decoded from the next count so all outputs change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter_x   <= X_LAST[CX_W-1:0];
            counter_y   <= Y_LAST[CY_W-1:0];
            h_sync      <= ~HS_POL;
            v_sync      <= ~VS_POL;
            in_display  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt   <= 8'd0;
`endif
        end else if (pix_en) begin
            counter_x   <= x_nxt;
            counter_y   <= y_nxt;
            h_sync      <= hs_act ? HS_POL : ~HS_POL;
            v_sync      <= vs_act ? VS_POL : ~VS_POL;
            in_display  <= de_nxt;
            line_start  <= x_wrap;
            frame_start <= x_wrap && y_wrap;
`ifdef VGA_FRAME_CNT_EN
            if (x_wrap && y_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
`endif
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a small 14x7 active-high instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       rst_d, rst_s, en_d, en_s_base, half_mode, tog;
    logic       en_s;
    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [3:0] s_x;
    logic [2:0] s_y;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] d_fc, s_fc;
`endif

    assign en_s = half_mode ? tog : en_s_base;
    initial tog = 1'b0;
    always begin
        @(posedge clk);
        #2;
        tog = ~tog;
    end

    vga_timing_gen u_def (
        .clk(clk), .reset_n(rst_d), .pix_en(en_d),
        .h_sync(d_hs), .v_sync(d_vs), .in_display(d_de),
        .counter_x(d_x), .counter_y(d_y), .line_start(d_ls),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt(d_fc),
`endif
        .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CX_W(4), .CY_W(3)
    ) u_small (
        .clk(clk), .reset_n(rst_s), .pix_en(en_s),
        .h_sync(s_hs), .v_sync(s_vs), .in_display(s_de),
        .counter_x(s_x), .counter_y(s_y), .line_start(s_ls),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt(s_fc),
`endif
        .frame_start(s_fs)
    );

    // Model state: number of pixel advances since reset, and whether the last edge advanced.
    int n_d, n_s;
    bit adv_d, adv_s;
    always @(posedge clk or negedge rst_d) begin
        if (!rst_d) begin n_d <= 0; adv_d <= 1'b0; end
        else begin adv_d <= en_d; if (en_d) n_d <= n_d + 1; end
    end
    always @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin n_s <= 0; adv_s <= 1'b0; end
        else begin adv_s <= en_s; if (en_s) n_s <= n_s + 1; end
    end

    typedef struct {
        int x; int y; bit hs; bit vs; bit de; bit ls; bit fs; int fc;
    } exp_t;

    // The n-th advance lands on raster position n-1 (x fastest); n=0 is the reset point.
    function automatic exp_t model(int n, bit adv, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb, bit hp, bit vp);
        exp_t e;
        int ht, vt, p;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (n == 0) begin
            e.x = ht - 1; e.y = vt - 1; e.fc = 0;
            e.ls = 1'b0; e.fs = 1'b0;
        end else begin
            p = (n - 1) % (ht * vt);
            e.x = p % ht; e.y = p / ht;
            e.fc = ((n - 1) / (ht * vt) + 1) % 256;
            e.ls = adv && (e.x == 0);
            e.fs = e.ls && (e.y == 0);
        end
        e.hs = (e.x >= ha + hf && e.x < ha + hf + hsw) ? hp : ~hp;
        e.vs = (e.y >= va + vf && e.y < va + vf + vsw) ? vp : ~vp;
        e.de = (e.x < ha) && (e.y < va);
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        e = model(n_d, adv_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        cmp("d_x", d_x, e.x);   cmp("d_y", d_y, e.y);
        cmp("d_hs", d_hs, e.hs); cmp("d_vs", d_vs, e.vs);
        cmp("d_de", d_de, e.de); cmp("d_ls", d_ls, e.ls); cmp("d_fs", d_fs, e.fs);
`ifdef VGA_FRAME_CNT_EN
        cmp("d_fc", d_fc, e.fc);
`endif
        e = model(n_s, adv_s, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
        cmp("s_x", s_x, e.x);   cmp("s_y", s_y, e.y);
        cmp("s_hs", s_hs, e.hs); cmp("s_vs", s_vs, e.vs);
        cmp("s_de", s_de, e.de); cmp("s_ls", s_ls, e.ls); cmp("s_fs", s_fs, e.fs);
`ifdef VGA_FRAME_CNT_EN
        cmp("s_fc", s_fc, e.fc);
`endif
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input string name);
        int k;
        k = 0;
        while (!s_fs && k < 500) begin step(1); k++; end
        cmp(name, s_fs, 1);
    endtask

    task automatic measure_period(input string name, input int req);
        int cnt;
        wait_fs({name, "_sync"});
        cnt = 0;
        do begin step(1); cnt++; end while (!s_fs && cnt < 500);
        cmp(name, cnt, req);
    endtask

    initial begin
        int nfs;
        rst_d = 1'b0; rst_s = 1'b0; en_d = 1'b0; en_s_base = 1'b0; half_mode = 1'b0;
        step(3);
        cmp("rst_d_x", d_x, 799); cmp("rst_d_y", d_y, 524);
        cmp("rst_d_hs", d_hs, 1); cmp("rst_d_vs", d_vs, 1); cmp("rst_d_de", d_de, 0);
        cmp("rst_s_x", s_x, 13);  cmp("rst_s_y", s_y, 6);  cmp("rst_s_hs", s_hs, 0);

        rst_d = 1'b1; rst_s = 1'b1; en_d = 1'b1; en_s_base = 1'b1;
        step(1);
        cmp("first_x", d_x, 0); cmp("first_y", d_y, 0);
        cmp("first_fs", d_fs, 1); cmp("first_ls", d_ls, 1); cmp("first_de", d_de, 1);
        step(1);
        cmp("fs_width", d_fs, 0); cmp("x_one", d_x, 1);
        step(639);
        cmp("de_fall_x", d_x, 640); cmp("de_fall", d_de, 0);
        step(16);
        cmp("hs_start_x", d_x, 656); cmp("hs_start", d_hs, 0);
        step(95);
        cmp("hs_last", d_hs, 0);
        step(1);
        cmp("hs_end_x", d_x, 752); cmp("hs_end", d_hs, 1);
        step(48);
        cmp("line2_x", d_x, 0); cmp("line2_y", d_y, 1); cmp("line2_ls", d_ls, 1);

        en_d = 1'b0;
        step(5);
        cmp("hold_x", d_x, 0); cmp("hold_y", d_y, 1); cmp("hold_ls", d_ls, 0);
        en_d = 1'b1;

        wait_fs("small_fs");
        step(5 * 14);
        cmp("small_y5", s_y, 5); cmp("small_vs_y5", s_vs, 1);
        step(10);
        cmp("small_x10", s_x, 10); cmp("small_hs_x10", s_hs, 1); cmp("small_de_y5", s_de, 0);
        measure_period("period_full", 98);

        half_mode = 1'b1;
        wait_fs("half_sync");
        measure_period("period_half", 196);
        half_mode = 1'b0;

        wait_fs("pre_reset_fs");
        step(3 * 14 + 5);
        cmp("pre_reset_x", s_x, 5); cmp("pre_reset_y", s_y, 3);
        #2;
        rst_s = 1'b0; rst_d = 1'b0;
        #1;
        cmp("arst_s_x", s_x, 13); cmp("arst_s_y", s_y, 6);
        cmp("arst_s_hs", s_hs, 0); cmp("arst_s_vs", s_vs, 0); cmp("arst_s_de", s_de, 0);
        cmp("arst_d_x", d_x, 799); cmp("arst_d_y", d_y, 524); cmp("arst_d_hs", d_hs, 1);
        step(2);
        rst_s = 1'b1; rst_d = 1'b1;

        nfs = 0;
        for (int k = 0; k < 30000 && nfs < 256; k++) begin
            step(1);
            if (s_fs) begin
                nfs++;
`ifdef VGA_FRAME_CNT_EN
                if (nfs == 1) cmp("fc_first", s_fc, 1);
                if (nfs == 255) cmp("fc_255", s_fc, 255);
                if (nfs == 256) cmp("fc_wrap", s_fc, 0);
`endif
            end
        end
        cmp("frames_seen", nfs, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
